// File: rtl/approx_mul_pipe.sv
// Pipelined signed approximate multiplier: drops K LSBs per operand, multiplies, rescales by 2^(2K).
// Optional per-transaction exact mode when APPROX_MUL_EXACT_EN is defined.
module approx_mul_pipe #(
    parameter int unsigned W      = 16,
    parameter int unsigned K      = 2,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               in_exact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     out_o,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_exact
);

    localparam int unsigned HW = W - K;
    localparam int unsigned PW = 2 * W;

    logic                    w_advance;
    logic signed [2*HW-1:0]  w_a_h;
    logic signed [2*HW-1:0]  w_b_h;
    logic signed [2*HW-1:0]  w_p_approx;
    logic [PW-1:0]           w_approx;
    logic [PW-1:0]           w_prod;
    logic                    w_exact_sel;
    logic                    w_unused;

    logic [STAGES-1:0]       r_valid;
    logic [STAGES-1:0]       r_exact;
    logic [PW-1:0]           r_prod [STAGES];
    logic [TAG_W-1:0]        r_tag  [STAGES];

    // Whole pipeline moves together; it only freezes when the head result is blocked.
    assign w_advance = out_ready | ~r_valid[STAGES-1];
    assign in_ready  = w_advance;

    // Truncated operands are sign-extended so the product's width equals its full range.
    assign w_a_h      = (2*HW)'($signed(in_a[W-1:K]));
    assign w_b_h      = (2*HW)'($signed(in_b[W-1:K]));
    assign w_p_approx = w_a_h * w_b_h;
    assign w_approx   = PW'(w_p_approx) << (2*K);

`ifdef APPROX_MUL_EXACT_EN
    logic signed [PW-1:0] w_a_x;
    logic signed [PW-1:0] w_b_x;
    logic signed [PW-1:0] w_p_exact;

    assign w_a_x       = PW'($signed(in_a));
    assign w_b_x       = PW'($signed(in_b));
    assign w_p_exact   = w_a_x * w_b_x;
    assign w_exact_sel = in_exact;
    assign w_prod      = in_exact ? PW'(w_p_exact) : w_approx;
`else
    assign w_exact_sel = 1'b0;
    assign w_prod      = w_approx;
`endif

    // Truncated LSBs and, in the approximate-only build, the mode request are intentionally dropped.
    assign w_unused = ^{in_exact, in_a, in_b};

    // Slice 0 captures the product; later slices are plain shift stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_exact <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                r_prod[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else if (w_advance) begin
            r_valid[0] <= in_valid;
            if (in_valid) begin
                r_prod[0]  <= w_prod;
                r_tag[0]   <= in_tag;
                r_exact[0] <= w_exact_sel;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_prod[i]  <= r_prod[i-1];
                    r_tag[i]   <= r_tag[i-1];
                    r_exact[i] <= r_exact[i-1];
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_o     = r_prod[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];
    assign out_exact = r_exact[STAGES-1];

endmodule

// File: doc/approx_mul_pipe.md
# approx_mul_pipe

Pipelined, parametrised signed approximate multiplier for the PE datapath. Each operand's K least-significant bits are truncated, the remaining (W-K)-bit signed operands are multiplied, and the product is left-shifted by 2K with zero fill. Operands enter through a valid/ready handshake, pass through a STAGES-deep pipeline with full backpressure, and leave with a pass-through tag. An optional exact mode can be compiled in and selected per transaction.

## Interface
Parameters:
- W, 16: operand width, signed two's complement; W >= 4
- K, 2: LSBs truncated per operand; 0 <= K <= W-2 (K=0 gives an exact product)
- STAGES, 2: pipeline depth, which is also the latency in cycles; STAGES >= 1
- TAG_W, 4: width of the sideband tag; TAG_W >= 1

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand pair presented
- in_ready  out  1  block accepts this cycle
- in_a  in  W  signed multiplicand
- in_b  in  W  signed multiplier
- in_tag  in  TAG_W  opaque tag, returned unchanged
- in_exact  in  1  request exact product (only meaningful with APPROX_MUL_EXACT_EN)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts this cycle
- out_o  out  2W  signed product
- out_tag  out  TAG_W  tag of the result
- out_exact  out  1  result was computed exactly

## Operation
- Approximate product: a_h = in_a[W-1:K] (signed), b_h = in_b[W-1:K] (signed), p = a_h*b_h (signed, 2(W-K) bits), out_o = {p, 2K'b0}.
- Exact product: out_o = in_a*in_b, full signed 2W bits.
- Pipeline is STAGES register slices, each holding valid, operands or partial product, tag and exact flag. The multiply may be placed in any slice; all sub-results must be bit-identical to the formulas above.
- advance = out_ready | ~out_valid. While advance is high every slice shifts forward by one; while it is low every slice holds.
- in_ready = advance (combinational from out_ready and the last slice's valid). A transfer occurs when in_valid & in_ready; an empty slot is inserted when in_valid is low and advance is high.
- An output transfer occurs when out_valid & out_ready. out_o, out_tag and out_exact stay stable while out_valid & ~out_ready.
- Transactions stay in order; none is dropped or duplicated.

## Timing
- Latency: a transaction accepted at edge n appears with out_valid high after edge n+STAGES, provided there is no stall. Each stall cycle adds one cycle.
- Throughput: one transaction per cycle while out_ready is held high.
- Reset: every slice valid is cleared. out_valid=0, out_o=0, out_tag=0, out_exact=0. in_ready=1 in the first cycle after reset (pipeline empty).
- Reset mid-operation: all in-flight transactions are discarded with no output. Inputs during the reset cycle are ignored.
- Simultaneous input and output transfer in the same cycle is legal; the pipeline is then neither filling nor draining.
- Full pipeline with out_ready low: in_ready=0 and no slice changes.
- Empty pipeline: out_valid=0 regardless of out_ready.

## Configuration
- APPROX_MUL_EXACT_EN defined: in_exact selects the exact product for that transaction, and out_exact echoes the selection.
- APPROX_MUL_EXACT_EN undefined: in_exact is ignored, every result is approximate, out_exact is tied to 0, and no exact-multiply logic is synthesised.

## Test plan
Defaults W=16, K=2, STAGES=2 unless stated.
- in_a=7, in_b=7, exact=0 -> out_o=16 after 2 cycles. in_a=-1, in_b=-1 -> out_o=16. in_a=-32768, in_b=-32768 -> out_o=0x40000000. in_a=3, in_b=100 -> out_o=0.
- With the macro defined, in_a=7, in_b=7, exact=1 -> out_o=49, out_exact=1. Without the macro, the same stimulus gives out_o=16, out_exact=0.
- Stream tags 0..15 back-to-back with out_ready=1 -> 16 results on consecutive cycles, in order, tags matching.
- Fill the pipeline, then drop out_ready for 5 cycles -> in_ready=0, outputs held stable, nothing lost. Raise out_ready -> drain in order.
- Assert reset with 2 transactions in flight -> no out_valid afterwards. All outputs read 0 and in_ready=1 in the cycle after reset.
- Random 10k operands for K in {0,2,5} and STAGES in {1,3} -> every out_o matches the reference formula. For K=0, out_o equals the exact product.
